// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO read-domain scheduler.
// Holds the FSM state encoding and the default sizing parameters.
package fifo_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_REQ_DEF    = 4;
    localparam int BURST_MAX_DEF  = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Read-port bundle between the FIFO read-pointer block, the consumers and the scheduler.
// The slave modport is the scheduler's view; master is the environment driving it.
interface fifo_read_arbiter_if
    import fifo_read_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int BURST_MAX  = BURST_MAX_DEF
) ();
    localparam int LW = $clog2(BURST_MAX);
    localparam int IW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]    REQ;
    logic [NUM_REQ*LW-1:0] REQ_LEN;
    logic                  EMPTY_FLAG;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  R_EN;
    logic [NUM_REQ-1:0]    GNT;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [IW-1:0]         OUT_ID;
    logic                  OUT_LAST;
    logic                  BUSY;

    modport slave (
        input  REQ, REQ_LEN, EMPTY_FLAG, RD_DATA, OUT_READY,
        output R_EN, GNT, OUT_DATA, OUT_VALID, OUT_ID, OUT_LAST, BUSY
    );

    modport master (
        output REQ, REQ_LEN, EMPTY_FLAG, RD_DATA, OUT_READY,
        input  R_EN, GNT, OUT_DATA, OUT_VALID, OUT_ID, OUT_LAST, BUSY
    );
endinterface

// File: rtl/fifo_read_arbiter_rr.sv
// Round-robin picker: combinational one-hot choice plus a registered search-start pointer.
// The pointer holds last_winner+1, so after reset the search begins at consumer 0.
module rr_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IW      = id_width(NUM_REQ)
) (
    input  logic               CLK_READ,
    input  logic               R_RST,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    input  logic [IW-1:0]      adv_id_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      win_o
);
    logic [IW-1:0] ptr_q;
    logic          found;

    always_comb begin
        int unsigned idx;
        gnt_o = '0;
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % 32'(NUM_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = IW'(idx);
            end
        end
    end

    always_ff @(posedge CLK_READ or negedge R_RST) begin
        if (!R_RST) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= (32'(adv_id_i) == 32'(NUM_REQ - 1)) ? '0 : adv_id_i + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_read_arbiter.sv
// Read-domain scheduler: round-robin burst grants on the shared FIFO read port,
// returning words through a 2-entry valid/ready buffer tagged with LAST.
module fifo_read_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int BURST_MAX  = BURST_MAX_DEF
) (
    input  logic                CLK_READ,
    input  logic                R_RST,
    fifo_read_arbiter_if.slave  bus
);
    localparam int LW = $clog2(BURST_MAX);
    localparam int IW = id_width(NUM_REQ);

    state_t                state_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [IW-1:0]         id_q;
    logic [LW:0]           rem_q;
    logic [LW:0]           rem_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [1:0]            cnt_q;
    logic [DATA_WIDTH-1:0] e0_data_q;
    logic [DATA_WIDTH-1:0] e1_data_q;
    logic                  e0_last_q;
    logic                  e1_last_q;

    logic [NUM_REQ-1:0]    pick;
    logic [IW-1:0]         win;
    logic [LW-1:0]         win_len;
    logic                  r_en;
    logic                  pop;
    logic                  push;
    logic                  advance;
    logic [1:0]            occ;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .CLK_READ (CLK_READ),
        .R_RST    (R_RST),
        .req_i    (bus.REQ),
        .adv_i    (advance),
        .adv_id_i (id_q),
        .gnt_o    (pick),
        .win_o    (win)
    );

    assign win_len = bus.REQ_LEN[int'(win)*LW +: LW];
    assign pop     = (cnt_q != 2'd0) && bus.OUT_READY;
    assign push    = inflight_q;
    assign rem_d   = rem_q - 1'b1;
    // Occupancy counts the word popped this cycle as freed, sustaining one word per cycle.
    assign occ     = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    assign r_en    = (state_q == ST_READ) && !bus.EMPTY_FLAG && (rem_q != '0) && (occ < 2'd2);
    assign advance = (state_q == ST_DRAIN) && (cnt_q == 2'd0) && !inflight_q;

    always_ff @(posedge CLK_READ or negedge R_RST) begin
        if (!R_RST) begin
            state_q         <= ST_IDLE;
            gnt_q           <= '0;
            id_q            <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q <= r_en;
            if (r_en) inflight_last_q <= (rem_d == '0);
            case (state_q)
                ST_IDLE: if (|bus.REQ) begin
                    gnt_q   <= pick;
                    id_q    <= win;
                    rem_q   <= {1'b0, win_len} + 1'b1;
                    state_q <= ST_READ;
                end
                ST_READ: if (r_en) begin
                    rem_q <= rem_d;
                    if (rem_d == '0) state_q <= ST_DRAIN;
                end
                ST_DRAIN: if (advance) begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_READ or negedge R_RST) begin
        if (!R_RST) begin
            cnt_q     <= '0;
            e0_data_q <= '0;
            e1_data_q <= '0;
            e0_last_q <= 1'b0;
            e1_last_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_data_q <= bus.RD_DATA;
                        e0_last_q <= inflight_last_q;
                    end else begin
                        e0_data_q <= e1_data_q;
                        e0_last_q <= e1_last_q;
                        e1_data_q <= bus.RD_DATA;
                        e1_last_q <= inflight_last_q;
                    end
                end
                2'b01: begin
                    e0_data_q <= e1_data_q;
                    e0_last_q <= e1_last_q;
                    cnt_q     <= cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_data_q <= bus.RD_DATA;
                        e0_last_q <= inflight_last_q;
                    end else begin
                        e1_data_q <= bus.RD_DATA;
                        e1_last_q <= inflight_last_q;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.R_EN      = r_en;
    assign bus.GNT       = gnt_q;
    assign bus.OUT_DATA  = e0_data_q;
    assign bus.OUT_VALID = (cnt_q != 2'd0);
    assign bus.OUT_LAST  = e0_last_q && (cnt_q != 2'd0);
    assign bus.OUT_ID    = id_q;
    assign bus.BUSY      = (state_q != ST_IDLE);
endmodule
